logic_op_issuer: RTL and testbench

Initiator side of the logical-unit interface. Accepts operation requests over a valid/ready channel and drives the operator/operand bus of a combinational logical_unit instance. After a programmable settle time it samples the unit's result and returns it over a valid/ready response channel. This block is the registered front end between the datapath controller and logical_unit.

---
 rtl/logic_op_issuer_pkg.sv | 26 ++
 rtl/logic_op_issuer.sv | 129 ++++++++++++
 tb/tb_logic_op_issuer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_op_issuer_pkg.sv
// Shared op-code, state and bus-width definitions for the logical-unit interface.
package logic_op_issuer_pkg;

    localparam int unsigned LU_OPERATOR_W = 8;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_2COMP = 3'b110;
    localparam logic [2:0] OP_XNOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } issuer_state_e;

    // Single-operand ops ignore op2; callers drive it to zero.
    function automatic logic is_unary_op(input logic [2:0] op);
        return (op == OP_NOT) || (op == OP_2COMP);
    endfunction

endpackage

// File: rtl/logic_op_issuer.sv
// Registered front end for logical_unit: accepts a request, holds the operand
// bus for SETTLE_CYCLES, captures the result and returns it on a response channel.
module logic_op_issuer
    import logic_op_issuer_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    output logic [LU_OPERATOR_W-1:0] lu_operator,
    output logic [WIDTH-1:0]         lu_op1,
    output logic [WIDTH-1:0]         lu_op2,
    input  logic [WIDTH-1:0]         lu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [2:0]               rsp_op,
    output logic                     rsp_zero,
    output logic                     busy,
    output logic [COUNT_W-1:0]       op_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("logic_op_issuer: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    issuer_state_e              state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [LU_OPERATOR_W-1:0]   lu_operator_q, lu_operator_d;
    logic [WIDTH-1:0]           lu_op1_q, lu_op1_d;
    logic [WIDTH-1:0]           lu_op2_q, lu_op2_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]           rsp_data_q, rsp_data_d;
    logic [2:0]                 rsp_op_q, rsp_op_d;
    logic                       rsp_zero_q, rsp_zero_d;
    logic [COUNT_W-1:0]         op_count_q, op_count_d;

    // Next-state, operand-bus and response-capture logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lu_operator_d = lu_operator_q;
        lu_op1_d      = lu_op1_q;
        lu_op2_d      = lu_op2_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_op_d      = rsp_op_q;
        rsp_zero_d    = rsp_zero_q;
        op_count_d    = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    lu_operator_d = LU_OPERATOR_W'(req_op);
                    lu_op1_d      = req_a;
                    lu_op2_d      = is_unary_op(req_op) ? '0 : req_b;
                    cnt_d         = SETTLE_INIT;
                    state_d       = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = lu_out;
                    rsp_op_d    = lu_operator_q[2:0];
                    rsp_zero_d  = (lu_out == '0);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + COUNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            lu_operator_q <= '0;
            lu_op1_q      <= '0;
            lu_op2_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_op_q      <= '0;
            rsp_zero_q    <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lu_operator_q <= lu_operator_d;
            lu_op1_q      <= lu_op1_d;
            lu_op2_q      <= lu_op2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_op_q      <= rsp_op_d;
            rsp_zero_q    <= rsp_zero_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign lu_operator = lu_operator_q;
    assign lu_op1      = lu_op1_q;
    assign lu_op2      = lu_op2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_zero    = rsp_zero_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_logic_op_issuer.sv
// Directed scoreboard bench for logic_op_issuer with a behavioural logical_unit.
module tb_logic_op_issuer;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  op;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;
    logic req_valid, rsp_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;

    // Instance with SETTLE_CYCLES=1, COUNT_W=4
    logic        req_valid_1, rsp_ready_1, req_ready_1, rsp_valid_1, rsp_zero_1, busy_1;
    logic [7:0]  lu_operator_1;
    logic [31:0] lu_op1_1, lu_op2_1, lu_out_1, rsp_data_1;
    logic [2:0]  rsp_op_1;
    logic [3:0]  op_count_1;
    // Instance with SETTLE_CYCLES=4, COUNT_W=16
    logic        req_valid_4, rsp_ready_4, req_ready_4, rsp_valid_4, rsp_zero_4, busy_4;
    logic [7:0]  lu_operator_4;
    logic [31:0] lu_op1_4, lu_op2_4, lu_out_4, rsp_data_4;
    logic [2:0]  rsp_op_4;
    logic [15:0] op_count_4;

    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    int   accept_cyc = 0;
    exp_t exp_q[$];
    logic [7:0]  exp_operator;
    logic [31:0] exp_op1, exp_op2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural logical_unit responder.
    function automatic logic [31:0] lu_model(input logic [7:0] opr, input logic [31:0] a, input logic [31:0] b);
        case (opr[2:0])
            3'd0: return a & b;
            3'd1: return a ^ b;
            3'd2: return ~(a & b);
            3'd3: return a | b;
            3'd4: return ~a;
            3'd5: return ~(a | b);
            3'd6: return 32'd0 - a;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign lu_out_1    = lu_model(lu_operator_1, lu_op1_1, lu_op2_1);
    assign lu_out_4    = lu_model(lu_operator_4, lu_op1_4, lu_op2_4);
    assign req_valid_1 = req_valid && !sel;
    assign rsp_ready_1 = rsp_ready && !sel;
    assign req_valid_4 = req_valid && sel;
    assign rsp_ready_4 = rsp_ready && sel;

    // Observation view of the selected instance.
    logic        v_req_ready, v_rsp_valid, v_rsp_zero, v_busy;
    logic [7:0]  v_lu_operator;
    logic [31:0] v_lu_op1, v_lu_op2, v_rsp_data;
    logic [2:0]  v_rsp_op;
    logic [15:0] v_op_count;
    assign v_req_ready   = sel ? req_ready_4   : req_ready_1;
    assign v_rsp_valid   = sel ? rsp_valid_4   : rsp_valid_1;
    assign v_rsp_zero    = sel ? rsp_zero_4    : rsp_zero_1;
    assign v_busy        = sel ? busy_4        : busy_1;
    assign v_lu_operator = sel ? lu_operator_4 : lu_operator_1;
    assign v_lu_op1      = sel ? lu_op1_4      : lu_op1_1;
    assign v_lu_op2      = sel ? lu_op2_4      : lu_op2_1;
    assign v_rsp_data    = sel ? rsp_data_4    : rsp_data_1;
    assign v_rsp_op      = sel ? rsp_op_4      : rsp_op_1;
    assign v_op_count    = sel ? op_count_4    : {12'd0, op_count_1};

    logic_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(1), .COUNT_W(4)) u_s1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .lu_operator(lu_operator_1), .lu_op1(lu_op1_1), .lu_op2(lu_op2_1), .lu_out(lu_out_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_data(rsp_data_1),
        .rsp_op(rsp_op_1), .rsp_zero(rsp_zero_1), .busy(busy_1), .op_count(op_count_1)
    );

    logic_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(4), .COUNT_W(16)) u_s4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .lu_operator(lu_operator_4), .lu_op1(lu_op1_4), .lu_op2(lu_op2_4), .lu_out(lu_out_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_data(rsp_data_4),
        .rsp_op(rsp_op_4), .rsp_zero(rsp_zero_4), .busy(busy_4), .op_count(op_count_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(v_req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(v_busy), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(v_rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, v_rsp_data, 32'd0);
        chk({tag, "_rsp_op"}, 32'(v_rsp_op), 32'd0);
        chk({tag, "_rsp_zero"}, 32'(v_rsp_zero), 32'd0);
        chk({tag, "_lu_operator"}, 32'(v_lu_operator), 32'd0);
        chk({tag, "_lu_op1"}, v_lu_op1, 32'd0);
        chk({tag, "_lu_op2"}, v_lu_op2, 32'd0);
        chk({tag, "_op_count"}, 32'(v_op_count), 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data);
        int n = 0;
        while (!v_req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_ready_wait", 32'(v_req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        exp_q.push_back('{data: exp_data, op: op, zero: (exp_data == 32'd0)});
        exp_operator = {5'd0, op};
        exp_op1 = a;
        exp_op2 = (op == 3'b100 || op == 3'b110) ? 32'd0 : b;
        step();
        accept_cyc = cyc;
        // Scramble request fields: they must only be sampled at acceptance.
        req_valid = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b;
    endtask

    task automatic collect(input int hold, input int settle, input int count_before);
        int   n = 0;
        exp_t e;
        while (!v_rsp_valid && n < 50) begin
            chk("drive_lu_operator", 32'(v_lu_operator), 32'(exp_operator));
            chk("drive_lu_op1", v_lu_op1, exp_op1);
            chk("drive_lu_op2", v_lu_op2, exp_op2);
            chk("drive_busy", 32'(v_busy), 32'd1);
            chk("drive_req_ready", 32'(v_req_ready), 32'd0);
            step();
            n++;
        end
        chk("rsp_latency", 32'(cyc - accept_cyc), 32'(settle));
        if (exp_q.size() == 0) begin
            vectors++;
            fails++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            e = '{data: 32'd0, op: 3'd0, zero: 1'b0};
        end else begin
            e = exp_q.pop_front();
        end
        rsp_ready = 1'b0;
        repeat (hold) begin
            step();
            chk("hold_rsp_valid", 32'(v_rsp_valid), 32'd1);
            chk("hold_rsp_data", v_rsp_data, e.data);
            chk("hold_req_ready", 32'(v_req_ready), 32'd0);
            chk("hold_busy", 32'(v_busy), 32'd1);
            chk("hold_op_count", 32'(v_op_count), 32'(count_before));
        end
        chk("rsp_data", v_rsp_data, e.data);
        chk("rsp_op", 32'(v_rsp_op), 32'(e.op));
        chk("rsp_zero", 32'(v_rsp_zero), 32'(e.zero));
        chk("pre_hs_op_count", 32'(v_op_count), 32'(count_before));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 32'(v_rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(v_req_ready), 32'd1);
        chk("post_hs_op_count", 32'(v_op_count), 32'(count_before + 1));
        chk("post_hs_lu_op1_held", v_lu_op1, exp_op1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   issued, got, last, c;
        logic acc;
        logic [31:0] na, nb;
        exp_t e;

        sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
        repeat (2) step();
        check_idle_reset("reset");
        rst_n = 1'b1;
        step();

        // SETTLE_CYCLES=1 instance
        issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        collect(0, 1, 0);
        issue(3'b110, 32'h0000_0001, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        collect(0, 1, 1);
        issue(3'b110, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000);
        collect(0, 1, 2);
        issue(3'b111, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF);
        collect(5, 1, 3);
        issue(3'b100, 32'h0F0F_0F0F, 32'h5555_5555, 32'hF0F0_F0F0);
        collect(1, 1, 4);

        // SETTLE_CYCLES=4 instance
        sel = 1'b1;
        #1;
        issue(3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF);
        collect(0, 4, 0);

        // Asynchronous reset in the middle of DRIVE
        issue(3'b001, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_5555);
        step();
        step();
        chk("mid_drive_busy", 32'(v_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_reset("async_rst");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("no_rsp_after_rst", 32'(v_rsp_valid), 32'd0);
        end
        issue(3'b001, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        collect(0, 4, 0);

        // Back-to-back NOR on the COUNT_W=4 instance: wrap and throughput
        sel = 1'b0;
        #1;
        rsp_ready = 1'b1;
        issued = 0; got = 0; last = 0;
        na = 32'd0; nb = 32'h8000_0000;
        req_op = 3'b101; req_a = na; req_b = nb; req_valid = 1'b1;
        exp_q.push_back('{data: ~(na | nb), op: 3'b101, zero: ((na | nb) == 32'hFFFF_FFFF)});
        for (c = 0; c < 200 && got < 16; c++) begin
            acc = v_req_ready && req_valid;
            step();
            if (acc) begin
                issued++;
                if (issued < 16) begin
                    na = 32'(issued) * 32'h0101_0101;
                    nb = 32'h8000_0000 >> issued;
                    if (issued == 15) begin
                        na = 32'hFFFF_FFFF;
                    end
                    req_a = na; req_b = nb;
                    exp_q.push_back('{data: ~(na | nb), op: 3'b101, zero: ((na | nb) == 32'hFFFF_FFFF)});
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (v_rsp_valid) begin
                e = exp_q.pop_front();
                chk("nor_rsp_data", v_rsp_data, e.data);
                chk("nor_rsp_zero", 32'(v_rsp_zero), 32'(e.zero));
                chk("nor_op_count", 32'(v_op_count), 32'(got % 16));
                if (got > 0) begin
                    chk("nor_spacing", 32'(cyc - last), 32'd3);
                end
                last = cyc;
                got++;
            end
        end
        chk("nor_responses", 32'(got), 32'd16);
        step();
        rsp_ready = 1'b0;
        chk("nor_wrap_op_count", 32'(v_op_count), 32'd0);
        chk("nor_final_rsp_valid", 32'(v_rsp_valid), 32'd0);
        chk("nor_final_req_ready", 32'(v_req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
